// File: rtl/crc_pkg.sv
// crc_pkg: opcodes, FSM states and MODE field positions shared by the CRC byte front end
package crc_pkg;
  localparam logic [2:0] CMD_TAPS = 3'd0;
  localparam logic [2:0] CMD_INIT = 3'd1;
  localparam logic [2:0] CMD_MODE = 3'd2;
  localparam logic [2:0] CMD_LOAD = 3'd3;
  localparam logic [2:0] CMD_DATA = 3'd4;
  localparam logic [2:0] CMD_READ = 3'd5;
  localparam int LSB_FIRST_BIT = 7;
  localparam int MODE_WIDTH_BITS = 6;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DRAIN} state_t;
endpackage

// File: rtl/crc_bit_serializer.sv
// crc_bit_serializer: latches a byte and presents it one bit per clock for 8 clocks
module crc_bit_serializer (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       lsb_first,
  input  logic [7:0] byte_in,
  output logic       shift,
  output logic       data,
  output logic       done
);
  logic [7:0] latch;
  logic [2:0] cnt;
  logic       active;
  // capture the byte on start, then walk the counter through all 8 bit positions
  always_ff @(posedge clk) begin
    if (rst) begin
      latch  <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      latch  <= byte_in;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      cnt    <= cnt + 3'd1;
      active <= cnt != 3'd7;
    end
  end
  assign shift = active;
  assign done  = active && cnt == 3'd7;
  assign data  = active && (lsb_first ? latch[cnt] : latch[~cnt]);
endmodule

// File: rtl/crc_byte_ctrl.sv
// crc_byte_ctrl: byte-wide command front end that configures and feeds an lfsrN and streams its value out
module crc_byte_ctrl import crc_pkg::*; #(
  parameter  int WIDTH  = 64,
  localparam int NBYTES = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_cmd,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             lfsr_load,
  output logic             lfsr_shift,
  output logic             lfsr_data,
  output logic [5:0]       lfsr_bitwidth,
  output logic [WIDTH-1:0] lfsr_taps,
  output logic [WIDTH-1:0] lfsr_init,
  input  logic [WIDTH-1:0] lfsr_value
);
  state_t           state, next;
  logic [WIDTH-1:0] taps, init, snap, mask;
  logic [MODE_WIDTH_BITS-1:0] bitwidth;
  logic             lsb_first;
  logic [2:0]       idx;
  logic [7:0]       rd_byte;
  logic             accept, ser_done, last_hs;
  assign in_ready = state == IDLE && !rst;
  assign accept   = in_valid && in_ready;
  assign last_hs  = state == DRAIN && out_ready && idx == 3'd0;
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : next;
  // next state: commands only leave IDLE for LOAD, DATA and READ
  always_comb begin
    next = (state == IDLE && accept) ? (in_cmd == CMD_LOAD ? LOAD :
                                        in_cmd == CMD_DATA ? SHIFT :
                                        in_cmd == CMD_READ ? DRAIN : IDLE) :
           (state == LOAD) ? IDLE :
           (state == SHIFT && ser_done) ? IDLE :
           last_hs ? IDLE : state;
  end
  // configuration registers shift in a byte at a time, first byte ends up most significant
  always_ff @(posedge clk) begin
    if (rst) begin
      taps      <= '0;
      init      <= '0;
      bitwidth  <= '0;
      lsb_first <= 1'b0;
    end else if (accept) begin
      if (in_cmd == CMD_TAPS) taps <= (taps << 8) | WIDTH'(in_data);
      if (in_cmd == CMD_INIT) init <= (init << 8) | WIDTH'(in_data);
      if (in_cmd == CMD_MODE) begin
        bitwidth  <= in_data[MODE_WIDTH_BITS-1:0];
        lsb_first <= in_data[LSB_FIRST_BIT];
      end
    end
  end
  // keep only bits 0..bitwidth of the captured value
  always_comb begin
    mask = '0;
    for (int i = 0; i < WIDTH; i++) mask[i] = 6'(i) <= bitwidth;
  end
  // snapshot and byte index for readout, most significant byte first
  always_ff @(posedge clk) begin
    if (rst) begin
      snap <= '0;
      idx  <= '0;
    end else if (accept && in_cmd == CMD_READ) begin
      snap <= lfsr_value & mask;
      idx  <= bitwidth[5:3];
    end else if (state == DRAIN && out_ready && idx != 3'd0) begin
      idx <= idx - 3'd1;
    end
  end
  // select the current readout byte
  always_comb begin
    rd_byte = '0;
    for (int i = 0; i < NBYTES; i++) rd_byte = (3'(i) == idx) ? snap[i*8 +: 8] : rd_byte;
  end
  crc_bit_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && in_cmd == CMD_DATA),
    .lsb_first (lsb_first),
    .byte_in   (in_data),
    .shift     (lfsr_shift),
    .data      (lfsr_data),
    .done      (ser_done)
  );
  assign out_valid     = state == DRAIN;
  assign out_data      = out_valid ? rd_byte : 8'h00;
  assign lfsr_load     = state == LOAD;
  assign lfsr_bitwidth = bitwidth;
  assign lfsr_taps     = taps;
  assign lfsr_init     = init;
endmodule

// File: tb/tb_crc_byte_ctrl.sv
// tb_crc_byte_ctrl: directed self-checking bench with bit/byte scoreboards for crc_byte_ctrl
module tb_crc_byte_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_cmd = 3'd0;
  logic [7:0]  in_data = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        lfsr_load, lfsr_shift, lfsr_data;
  logic [5:0]  lfsr_bitwidth;
  logic [63:0] lfsr_taps, lfsr_init;
  logic [63:0] lfsr_value = 64'd0;
  int          checks = 0;
  int          fails = 0;
  logic        bit_q[$];
  logic [7:0]  byte_q[$];

  crc_byte_ctrl #(.WIDTH(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .lfsr_load(lfsr_load), .lfsr_shift(lfsr_shift), .lfsr_data(lfsr_data),
    .lfsr_bitwidth(lfsr_bitwidth), .lfsr_taps(lfsr_taps), .lfsr_init(lfsr_init),
    .lfsr_value(lfsr_value)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // returns one cycle after the accept edge
  task automatic send(input logic [2:0] cmd, input logic [7:0] data);
    int n;
    in_valid = 1'b1;
    in_cmd   = cmd;
    in_data  = data;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("send_timeout", 64'd0, 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_data(input logic [7:0] b, input logic lsb, input string tag);
    logic exp;
    for (int k = 0; k < 8; k++) bit_q.push_back(lsb ? b[k] : b[7-k]);
    send(3'd4, b);
    for (int k = 0; k < 8; k++) begin
      exp = bit_q.pop_front();
      chk({tag, "_shift"}, 64'(lfsr_shift), 64'd1);
      chk({tag, "_bit"}, 64'(lfsr_data), 64'(exp));
      chk({tag, "_rdy_low"}, 64'(in_ready), 64'd0);
      chk({tag, "_noload"}, 64'(lfsr_load), 64'd0);
      tick();
    end
    chk({tag, "_shift_end"}, 64'(lfsr_shift), 64'd0);
    chk({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_read(input string tag);
    int n;
    out_ready = 1'b0;
    send(3'd5, 8'd0);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_valid_hold"}, 64'(out_valid), 64'd1);
      chk({tag, "_data_hold"}, 64'(out_data), 64'(byte_q[0]));
      if (k < 2) tick();
    end
    out_ready = 1'b1;
    n = 0;
    while (byte_q.size() > 0 && n < 20) begin
      if (out_valid) chk({tag, "_byte"}, 64'(out_data), 64'(byte_q.pop_front()));
      tick();
      n++;
    end
    if (n >= 20) chk({tag, "_drain_timeout"}, 64'd0, 64'd1);
    out_ready = 1'b0;
    chk({tag, "_valid_end"}, 64'(out_valid), 64'd0);
    chk({tag, "_rdy_end"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    chk("rst_rdy_low", 64'(in_ready), 64'd0);
    rst = 1'b0;
    tick();
    chk("rst_rdy", 64'(in_ready), 64'd1);
    chk("rst_taps", lfsr_taps, 64'd0);
    chk("rst_init", lfsr_init, 64'd0);
    chk("rst_bw", 64'(lfsr_bitwidth), 64'd0);
    chk("rst_oval", 64'(out_valid), 64'd0);
    chk("rst_odata", 64'(out_data), 64'd0);
    chk("rst_shift", 64'(lfsr_shift), 64'd0);
    chk("rst_load", 64'(lfsr_load), 64'd0);

    for (int i = 1; i <= 8; i++) send(3'd0, 8'(i));
    chk("taps_8", lfsr_taps, 64'h0102030405060708);
    send(3'd0, 8'hAA);
    chk("taps_9", lfsr_taps, 64'h02030405060708AA);
    for (int i = 0; i < 8; i++) send(3'd1, 8'hFF);
    chk("init_ff", lfsr_init, 64'hFFFFFFFFFFFFFFFF);

    send(3'd6, 8'h55);
    chk("noop6_rdy", 64'(in_ready), 64'd1);
    chk("noop6_taps", lfsr_taps, 64'h02030405060708AA);
    send(3'd7, 8'h12);
    chk("noop7_rdy", 64'(in_ready), 64'd1);

    send(3'd2, 8'h07);
    chk("mode07_bw", 64'(lfsr_bitwidth), 64'd7);
    run_data(8'hC1, 1'b0, "msb");
    send(3'd2, 8'hC7);
    chk("mode87_bw", 64'(lfsr_bitwidth), 64'd7);
    run_data(8'hC1, 1'b1, "lsb");
    run_data(8'h5A, 1'b1, "lsb2");

    send(3'd3, 8'd0);
    chk("load_pulse", 64'(lfsr_load), 64'd1);
    chk("load_noshift", 64'(lfsr_shift), 64'd0);
    chk("load_rdy_low", 64'(in_ready), 64'd0);
    tick();
    chk("load_end", 64'(lfsr_load), 64'd0);
    chk("load_rdy", 64'(in_ready), 64'd1);

    lfsr_value = 64'h123456789ABCBEEF;
    send(3'd2, 8'h0F);
    byte_q.push_back(8'hBE);
    byte_q.push_back(8'hEF);
    run_read("rd16");
    send(3'd2, 8'h0B);
    byte_q.push_back(8'h0E);
    byte_q.push_back(8'hEF);
    run_read("rd12");
    send(3'd2, 8'h3F);
    for (int i = 7; i >= 0; i--) byte_q.push_back(lfsr_value[i*8 +: 8]);
    run_read("rd64");

    send(3'd2, 8'h07);
    send(3'd4, 8'hFF);
    tick();
    tick();
    tick();
    chk("mid_shift4", 64'(lfsr_shift), 64'd1);
    rst = 1'b1;
    tick();
    chk("mid_shift_off", 64'(lfsr_shift), 64'd0);
    chk("mid_taps", lfsr_taps, 64'd0);
    chk("mid_init", lfsr_init, 64'd0);
    chk("mid_bw", 64'(lfsr_bitwidth), 64'd0);
    chk("mid_rdy_low", 64'(in_ready), 64'd0);
    chk("mid_oval", 64'(out_valid), 64'd0);
    rst = 1'b0;
    tick();
    chk("mid_rdy", 64'(in_ready), 64'd1);
    chk("mid_shift_idle", 64'(lfsr_shift), 64'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
